td4_run_ctrl: RTL and testbench
===============================

// Module: td4_run_ctrl
// PURPOSE
//  Execution and program-load sequencer for the TD4 4-bit CPU core.
//  - Produces the CPU clock-enable in three ways: free-run at a selectable rate, single-step, or halted.
//  - Writes the CPU's 16x8 program memory from the 4 switches, one nibble per ENTER press.
//  - Holds the core in reset while a program is being loaded.
//  - Sits between the board buttons/switches and the core's clock-enable, reset and program-memory write port.
// PARAMETERS
//  DIV_SLOW  12_000_000  clock cycles per cpu_en pulse in RUN when speed=0 (must be >=2)
//  DIV_FAST  1_200_000   clock cycles per cpu_en pulse in RUN when speed=1 (must be >=2)
//  CNT_W     24          prescaler width; must satisfy 2**CNT_W > max(DIV_SLOW,DIV_FAST)
// PORTS
//  clock        in   1  system clock, all logic rising-edge
//  reset        in   1  asynchronous active-low reset
//  sw           in   4  switch nibble (program data)
//  btn_run      in   1  raw button: toggle HALT<->RUN
//  btn_step     in   1  raw button: single step while HALT
//  btn_load     in   1  raw button: enter/abort LOAD
//  btn_enter    in   1  raw button: accept nibble in LOAD
//  speed        in   1  0=DIV_SLOW, 1=DIV_FAST (level, sampled directly)
//  cpu_en       out  1  one-cycle pulse: CPU advances one instruction
//  cpu_rst_n    out  1  active-low reset to core, low during LOAD
//  prog_we      out  1  one-cycle program-memory write strobe
//  prog_addr    out  4  write address
//  prog_wdata   out  8  write data {opcode nibble, immediate nibble}
//  mode         out  2  00 HALT, 01 RUN, 10 LOAD_HI, 11 LOAD_LO
// BEHAVIOUR
//  - Reset: mode=HALT, cpu_en=0, cpu_rst_n=1, prog_we=0, prog_addr=0, prog_wdata=0, prescaler=0, sync/edge regs=0.
//    Reset asserted mid-operation aborts everything and issues no write.
//  - Button input path: each btn_* goes through a 2-FF synchronizer and then a rising-edge detector, giving one internal
//    press pulse per press. Raw-to-press-pulse latency is 2 clocks. The resulting registered output change is visible
//    3 rising edges after the raw high is first sampled. Held buttons give one pulse only.
//  - Press priority when presses coincide in one cycle: load > run > step > enter. Only the winner acts; the others are dropped.
//  - All outputs are registered.
//  - HALT:
//    - btn_run -> RUN, prescaler cleared.
//    - btn_step -> cpu_en=1 for exactly one cycle; mode stays HALT.
//    - btn_load -> LOAD_HI with prog_addr=0.
//    - btn_enter is ignored.
//  - RUN:
//    - Prescaler increments every cycle; DIV = speed ? DIV_FAST : DIV_SLOW.
//    - When prescaler >= DIV-1: cpu_en=1 for one cycle and the prescaler wraps to 0. The first pulse comes DIV cycles after
//      entering RUN. The >= comparison covers a mid-count speed change to a smaller DIV: the pulse occurs on the next cycle.
//    - btn_run -> HALT with no further cpu_en; a pulse due on that same cycle is suppressed.
//    - btn_load -> LOAD_HI with prog_addr=0.
//    - btn_step and btn_enter are ignored.
//  - LOAD_HI / LOAD_LO:
//    - cpu_rst_n=0 throughout; cpu_en is never asserted.
//    - LOAD_HI + btn_enter: prog_wdata[7:4] <= sw; -> LOAD_LO.
//    - LOAD_LO + btn_enter: prog_wdata[3:0] <= sw and prog_we=1 for one cycle, with prog_addr/prog_wdata valid in that same
//      cycle. On the following cycle prog_addr increments mod 16 and mode -> LOAD_HI.
//    - Write completed at prog_addr=15: prog_addr wraps to 0 and mode -> HALT, which ends LOAD automatically.
//    - btn_load in either LOAD state: abort -> HALT with no write; a pending high nibble is discarded. Bytes already
//      written are kept.
//    - btn_run and btn_step are ignored.
//  - cpu_rst_n returns to 1 on the same edge that mode leaves LOAD; the core restarts from its own reset state (ip=0).
//  - prog_addr and prog_wdata hold their values outside LOAD.
// TESTING  (bench overrides DIV_SLOW=8, DIV_FAST=3; buttons held >=4 cycles)
//  1 Reset, then press btn_run with speed=0 -> mode=01; cpu_en pulses every 8 cycles, first at cycle 8; press btn_run -> mode=00, no more pulses.
//  2 In HALT, press btn_step 3 times -> exactly 3 single-cycle cpu_en pulses; a btn_step held 20 cycles gives 1 pulse.
//  3 btn_load; enter sw=3,sw=C,sw=7,sw=9 -> prog_we at addr 0 data 8'h3C, then addr 1 data 8'h79; mode=10; cpu_rst_n=0 throughout.
//  4 Load all 16 bytes (byte i = {i, ~i}) -> 16 write strobes at addr 0..15, mode=HALT after the last one, prog_addr=0, cpu_rst_n=1.
//  5 LOAD_LO after sw=5, then press btn_load -> no prog_we, mode=HALT; btn_load and btn_run in the same cycle while in RUN -> LOAD_HI wins.
//  6 RUN speed=0 with prescaler=6, switch to speed=1 -> cpu_en on the next cycle, then every 3 cycles; deassert reset mid-LOAD -> all outputs at reset values.

Source files
------------

// File: rtl/td4_run_ctrl_if.sv
// rtl/td4_run_ctrl_if.sv - core-side control bundle: clock-enable, core reset, program-memory write port
interface td4_run_ctrl_if;
  logic       cpu_en;
  logic       cpu_rst_n;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_wdata;

  modport master (output cpu_en, output cpu_rst_n, output prog_we, output prog_addr, output prog_wdata);
  modport slave  (input  cpu_en, input  cpu_rst_n, input  prog_we, input  prog_addr, input  prog_wdata);
endinterface

// File: rtl/td4_run_ctrl.sv
// rtl/td4_run_ctrl.sv - TD4 run/step/halt sequencer and nibble-wise program loader
module td4_run_ctrl #(
  parameter int DIV_SLOW = 12_000_000,
  parameter int DIV_FAST = 1_200_000,
  parameter int CNT_W    = 24
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            sw,
  input  logic                  btn_run,
  input  logic                  btn_step,
  input  logic                  btn_load,
  input  logic                  btn_enter,
  input  logic                  speed,
  output logic [1:0]            mode,
  td4_run_ctrl_if.master        core
);

  typedef enum logic [1:0] {
    HALT    = 2'b00,
    RUN     = 2'b01,
    LOAD_HI = 2'b10,
    LOAD_LO = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] SLOW_M1 = CNT_W'(DIV_SLOW - 1);
  localparam logic [CNT_W-1:0] FAST_M1 = CNT_W'(DIV_FAST - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic             en_q, en_d;
  logic             rst_n_q, rst_n_d;
  logic             we_q, we_d;
  logic [3:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;

  // Button bits ordered {load, run, step, enter}, i.e. highest priority first
  logic [3:0] btn_s1, btn_s2, btn_prev, press;
  logic       p_load, p_run, p_step, p_enter;
  logic [CNT_W-1:0] div_m1;

  assign press   = btn_s2 & ~btn_prev;
  assign p_load  = press[3];
  assign p_run   = press[2] & ~press[3];
  assign p_step  = press[1] & ~|press[3:2];
  assign p_enter = press[0] & ~|press[3:1];
  assign div_m1  = speed ? FAST_M1 : SLOW_M1;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    en_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      HALT: begin
        if (p_load) begin
          state_d = LOAD_HI;
          addr_d  = 4'd0;
        end else if (p_run) begin
          state_d = RUN;
          presc_d = '0;
        end else if (p_step) begin
          en_d = 1'b1;
        end
      end
      RUN: begin
        if (p_load) begin
          state_d = LOAD_HI;
          addr_d  = 4'd0;
        end else if (p_run) begin
          state_d = HALT;
        end else if (presc_q >= div_m1) begin
          en_d    = 1'b1;
          presc_d = '0;
        end else begin
          presc_d = presc_q + CNT_W'(1);
        end
      end
      LOAD_HI: begin
        if (p_load) begin
          state_d = HALT;
        end else if (p_enter) begin
          wdata_d[7:4] = sw;
          state_d      = LOAD_LO;
        end
      end
      LOAD_LO: begin
        // The cycle after the strobe advances the address; the last byte ends LOAD
        if (we_q) begin
          addr_d  = addr_q + 4'd1;
          state_d = (p_load || addr_q == 4'hF) ? HALT : LOAD_HI;
        end else if (p_load) begin
          state_d = HALT;
        end else if (p_enter) begin
          wdata_d[3:0] = sw;
          we_d         = 1'b1;
        end
      end
      default: state_d = HALT;
    endcase
    rst_n_d = ~state_d[1];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_s1   <= 4'd0;
      btn_s2   <= 4'd0;
      btn_prev <= 4'd0;
      state_q  <= HALT;
      presc_q  <= '0;
      en_q     <= 1'b0;
      rst_n_q  <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= 4'd0;
      wdata_q  <= 8'd0;
    end else begin
      btn_s1   <= {btn_load, btn_run, btn_step, btn_enter};
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
      state_q  <= state_d;
      presc_q  <= presc_d;
      en_q     <= en_d;
      rst_n_q  <= rst_n_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign mode            = state_q;
  assign core.cpu_en     = en_q;
  assign core.cpu_rst_n  = rst_n_q;
  assign core.prog_we    = we_q;
  assign core.prog_addr  = addr_q;
  assign core.prog_wdata = wdata_q;

endmodule

// File: tb/tb_td4_run_ctrl.sv
// tb/tb_td4_run_ctrl.sv - directed bench for td4_run_ctrl
module tb_td4_run_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] sw;
  logic       btn_run, btn_step, btn_load, btn_enter, speed;
  logic [1:0] mode;

  td4_run_ctrl_if core_if ();

  td4_run_ctrl #(.DIV_SLOW(8), .DIV_FAST(3), .CNT_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .sw        (sw),
    .btn_run   (btn_run),
    .btn_step  (btn_step),
    .btn_load  (btn_load),
    .btn_enter (btn_enter),
    .speed     (speed),
    .mode      (mode),
    .core      (core_if)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] mask;
    logic [3:0] sw;
    logic [1:0] mode;
    logic       rst_n;
    logic [3:0] addr;
    logic [7:0] wdata;
    int         n_en;
    int         n_we;
    logic [3:0] we_addr;
    logic [7:0] we_data;
  } vec_t;

  vec_t       vecs[13];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         en_ticks[$];
  int         we_cnt;
  int         rst_bad;
  logic [3:0] we_addr_s;
  logic [7:0] we_data_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // mask = {load, run, step, enter}; buttons held for 'hold' ticks, window lasts n ticks
  task automatic window(input logic [3:0] mask, input int hold, input int n);
    en_ticks.delete();
    we_cnt  = 0;
    rst_bad = 0;
    {btn_load, btn_run, btn_step, btn_enter} = mask;
    for (int t = 1; t <= n; t++) begin
      tick();
      if (t == hold) {btn_load, btn_run, btn_step, btn_enter} = 4'b0000;
      if (core_if.cpu_en) en_ticks.push_back(t);
      if (core_if.prog_we) begin
        we_cnt++;
        we_addr_s = core_if.prog_addr;
        we_data_s = core_if.prog_wdata;
      end
      if (mode[1] && core_if.cpu_rst_n) rst_bad++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mode"},  32'(mode), 32'd0);
    check({tag, "_en"},    32'(core_if.cpu_en), 32'd0);
    check({tag, "_rstn"},  32'(core_if.cpu_rst_n), 32'd1);
    check({tag, "_we"},    32'(core_if.prog_we), 32'd0);
    check({tag, "_addr"},  32'(core_if.prog_addr), 32'd0);
    check({tag, "_wdata"}, 32'(core_if.prog_wdata), 32'd0);
  endtask

  initial begin
    logic [3:0] nib;

    vecs[0]  = '{4'b0010, 4'h0, 2'd0, 1'b1, 4'd0, 8'h00, 1, 0, 4'd0, 8'h00};
    vecs[1]  = '{4'b0010, 4'h0, 2'd0, 1'b1, 4'd0, 8'h00, 1, 0, 4'd0, 8'h00};
    vecs[2]  = '{4'b0010, 4'h0, 2'd0, 1'b1, 4'd0, 8'h00, 1, 0, 4'd0, 8'h00};
    vecs[3]  = '{4'b0001, 4'h0, 2'd0, 1'b1, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00};
    vecs[4]  = '{4'b1000, 4'h0, 2'd2, 1'b0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00};
    vecs[5]  = '{4'b0001, 4'h3, 2'd3, 1'b0, 4'd0, 8'h30, 0, 0, 4'd0, 8'h00};
    vecs[6]  = '{4'b0001, 4'hC, 2'd2, 1'b0, 4'd1, 8'h3C, 0, 1, 4'd0, 8'h3C};
    vecs[7]  = '{4'b0001, 4'h7, 2'd3, 1'b0, 4'd1, 8'h7C, 0, 0, 4'd0, 8'h00};
    vecs[8]  = '{4'b0001, 4'h9, 2'd2, 1'b0, 4'd2, 8'h79, 0, 1, 4'd1, 8'h79};
    vecs[9]  = '{4'b0010, 4'h0, 2'd2, 1'b0, 4'd2, 8'h79, 0, 0, 4'd0, 8'h00};
    vecs[10] = '{4'b0100, 4'h0, 2'd2, 1'b0, 4'd2, 8'h79, 0, 0, 4'd0, 8'h00};
    vecs[11] = '{4'b0001, 4'h5, 2'd3, 1'b0, 4'd2, 8'h59, 0, 0, 4'd0, 8'h00};
    vecs[12] = '{4'b1000, 4'h0, 2'd0, 1'b1, 4'd2, 8'h59, 0, 0, 4'd0, 8'h00};

    {btn_load, btn_run, btn_step, btn_enter} = 4'b0000;
    sw    = 4'h0;
    speed = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) tick();
    check_reset_vals("reset");
    reset = 1'b1;
    repeat (2) tick();

    // RUN at DIV 8; second toggle lands on the cycle a pulse is due
    window(4'b0100, 4, 24);
    check("run_mode", 32'(mode), 32'd1);
    check("run_pulses", 32'(en_ticks.size()), 32'd2);
    if (en_ticks.size() == 2) begin
      check("run_first", 32'(en_ticks[0]), 32'd11);
      check("run_second", 32'(en_ticks[1]), 32'd19);
    end
    window(4'b0100, 4, 20);
    check("halt_mode", 32'(mode), 32'd0);
    check("halt_no_pulse", 32'(en_ticks.size()), 32'd0);

    for (int i = 0; i < 13; i++) begin
      sw = vecs[i].sw;
      window(vecs[i].mask, 4, 8);
      check($sformatf("v%0d_mode", i), 32'(mode), 32'(vecs[i].mode));
      check($sformatf("v%0d_rstn", i), 32'(core_if.cpu_rst_n), 32'(vecs[i].rst_n));
      check($sformatf("v%0d_addr", i), 32'(core_if.prog_addr), 32'(vecs[i].addr));
      check($sformatf("v%0d_wdata", i), 32'(core_if.prog_wdata), 32'(vecs[i].wdata));
      check($sformatf("v%0d_en", i), 32'(en_ticks.size()), 32'(vecs[i].n_en));
      check($sformatf("v%0d_we", i), 32'(we_cnt), 32'(vecs[i].n_we));
      check($sformatf("v%0d_rst_in_load", i), 32'(rst_bad), 32'd0);
      if (vecs[i].n_we > 0) begin
        check($sformatf("v%0d_we_addr", i), 32'(we_addr_s), 32'(vecs[i].we_addr));
        check($sformatf("v%0d_we_data", i), 32'(we_data_s), 32'(vecs[i].we_data));
      end
    end

    // Held step gives a single pulse
    window(4'b0010, 20, 24);
    check("held_step_pulses", 32'(en_ticks.size()), 32'd1);

    // Full 16-byte load ends in HALT
    window(4'b1000, 4, 8);
    check("full_load_addr0", 32'(core_if.prog_addr), 32'd0);
    for (int i = 0; i < 16; i++) begin
      nib = 4'(i);
      sw = nib;
      window(4'b0001, 4, 8);
      sw = ~nib;
      window(4'b0001, 4, 8);
      check($sformatf("byte%0d_we", i), 32'(we_cnt), 32'd1);
      check($sformatf("byte%0d_addr", i), 32'(we_addr_s), 32'(nib));
      check($sformatf("byte%0d_data", i), 32'(we_data_s), 32'({nib, ~nib}));
    end
    check("full_load_mode", 32'(mode), 32'd0);
    check("full_load_addr", 32'(core_if.prog_addr), 32'd0);
    check("full_load_rstn", 32'(core_if.cpu_rst_n), 32'd1);

    // Load beats run when pressed together in RUN
    window(4'b0100, 4, 8);
    check("prio_run_mode", 32'(mode), 32'd1);
    window(4'b1100, 4, 8);
    check("prio_mode", 32'(mode), 32'd2);
    check("prio_rstn", 32'(core_if.cpu_rst_n), 32'd0);
    window(4'b1000, 4, 8);
    check("prio_abort_mode", 32'(mode), 32'd0);

    // Mid-count speed change to the fast divider
    speed = 1'b0;
    window(4'b0100, 4, 9);
    check("speed_pre_pulses", 32'(en_ticks.size()), 32'd0);
    speed = 1'b1;
    window(4'b0000, 4, 8);
    check("speed_pulses", 32'(en_ticks.size()), 32'd3);
    if (en_ticks.size() == 3) begin
      check("speed_p0", 32'(en_ticks[0]), 32'd1);
      check("speed_p1", 32'(en_ticks[1]), 32'd4);
      check("speed_p2", 32'(en_ticks[2]), 32'd7);
    end

    // Asynchronous reset in the middle of LOAD
    window(4'b1000, 4, 8);
    sw = 4'hA;
    window(4'b0001, 4, 8);
    check("midload_mode", 32'(mode), 32'd3);
    check("midload_wdata", 32'(core_if.prog_wdata), 32'hA0);
    reset = 1'b0;
    #1;
    check_reset_vals("async_reset");
    reset = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
